// File: rtl/spi_dma_mb.sv
`default_nettype none
// ============================================================================
// spi_dma_mb : block DMA between an SPI byte engine and a byte-wide RAM,
//              moving nblocks * 2^BLK_LOG2 bytes in either direction.
// Revision   : 1.0
// ============================================================================
module spi_dma_mb #(
  parameter int         ADDR_W   = 16,
  parameter int         BLK_LOG2 = 9,
  parameter int         NBLK_W   = 3,
  parameter logic [7:0] FILL     = 8'hFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              start,
  input  logic              dir,
  input  logic [NBLK_W-1:0] nblocks,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              abort,
  output logic [ADDR_W-1:0] oaddr,
  output logic [7:0]        odata,
  input  logic [7:0]        idata,
  output logic              owren,
  output logic              ready,
  output logic              done,
  output logic              aborted,
  output logic [7:0]        ospi_data,
  input  logic [7:0]        ispi_data,
  output logic              ospi_wr,
  input  logic              ispi_dsr,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_STORE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam logic [BLK_LOG2-1:0] C_LAST_BYTE = {BLK_LOG2{1'b1}};
  localparam logic [NBLK_W-1:0]   C_ONE_BLK   = NBLK_W'(1);

  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic [NBLK_W-1:0]   blkctr_q, blkctr_d;
  logic [BLK_LOG2-1:0] bytectr_q, bytectr_d;
  logic [ADDR_W-1:0]   oaddr_q, oaddr_d;
  logic [7:0]          odata_q, odata_d;
  logic [7:0]          ospi_data_q, ospi_data_d;
  logic                ospi_wr_q, ospi_wr_d;
  logic                owren_q, owren_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                w_active;

  assign w_active = (state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_STORE);

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    blkctr_d    = blkctr_q;
    bytectr_d   = bytectr_q;
    oaddr_d     = oaddr_q;
    odata_d     = odata_q;
    ospi_data_d = ospi_data_q;
    ospi_wr_d   = ospi_wr_q;
    owren_d     = owren_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    aborted_d   = aborted_q;

    if (w_active && abort) begin
      // Abort wins over any per-state update, including the STORE address bump.
      ospi_wr_d = 1'b0;
      owren_d   = 1'b0;
      aborted_d = 1'b1;
      state_d   = S_FIN;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && (nblocks != '0)) begin
            dir_d     = dir;
            blkctr_d  = nblocks;
            oaddr_d   = iaddr;
            bytectr_d = '0;
            aborted_d = 1'b0;
            ready_d   = 1'b0;
            state_d   = S_LOAD;
          end
        end
        S_LOAD: begin
          ospi_data_d = dir_q ? idata : FILL;
          ospi_wr_d   = 1'b1;
          state_d     = S_WAIT;
        end
        S_WAIT: begin
          ospi_wr_d = 1'b0;
          if (ispi_dsr) begin
            odata_d = ispi_data;
            owren_d = ~dir_q;
            state_d = S_STORE;
          end
        end
        S_STORE: begin
          owren_d   = 1'b0;
          oaddr_d   = oaddr_q + 1'b1;
          bytectr_d = bytectr_q + 1'b1;
          state_d   = S_LOAD;
          if (bytectr_q == C_LAST_BYTE) begin
            if (blkctr_q == C_ONE_BLK) begin
              state_d = S_FIN;
            end else begin
              blkctr_d = blkctr_q - 1'b1;
            end
          end
        end
        S_FIN: begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      blkctr_q    <= '0;
      bytectr_q   <= '0;
      oaddr_q     <= '0;
      odata_q     <= '0;
      ospi_data_q <= '0;
      ospi_wr_q   <= 1'b0;
      owren_q     <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else if (ce) begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      blkctr_q    <= blkctr_d;
      bytectr_q   <= bytectr_d;
      oaddr_q     <= oaddr_d;
      odata_q     <= odata_d;
      ospi_data_q <= ospi_data_d;
      ospi_wr_q   <= ospi_wr_d;
      owren_q     <= owren_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign oaddr     = oaddr_q;
  assign odata     = odata_q;
  assign ospi_data = ospi_data_q;
  assign ospi_wr   = ospi_wr_q;
  assign owren     = owren_q;
  assign ready     = ready_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_dma_mb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_spi_dma_mb : directed bench for spi_dma_mb with an SPI echo model and
//                 an asynchronous-read RAM model.
// Revision      : 1.0
// ============================================================================
module tb_spi_dma_mb;
  localparam int ADDR_W = 16;
  localparam int NBLK_W = 3;
  localparam int LIMIT  = 20000;

  logic              clk = 1'b0;
  logic              reset_n, ce, start, dir, abort, ispi_dsr;
  logic [NBLK_W-1:0] nblocks;
  logic [ADDR_W-1:0] iaddr, oaddr;
  logic [7:0]        odata, idata, ospi_data, ispi_data;
  logic              owren, ready, done, aborted, ospi_wr;
  logic [2:0]        state_o;

  logic [7:0] mem [0:65535];
  int n_checks = 0;
  int n_pass   = 0;
  bit ce_slow  = 1'b0;
  int dsr_hold = 1;

  // monitor-owned counters (reset whenever a transfer is accepted)
  int                wr_cnt, wren_cnt, done_cnt, mon_err;
  logic [ADDR_W-1:0] mon_base;
  logic              mon_dir;

  spi_dma_mb dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .start(start), .dir(dir),
    .nblocks(nblocks), .iaddr(iaddr), .abort(abort), .oaddr(oaddr),
    .odata(odata), .idata(idata), .owren(owren), .ready(ready), .done(done),
    .aborted(aborted), .ospi_data(ospi_data), .ispi_data(ispi_data),
    .ospi_wr(ospi_wr), .ispi_dsr(ispi_dsr), .state_o(state_o)
  );

  always #5 clk = ~clk;
  assign idata = mem[oaddr];

  // clock enable: always on, or one clock in three
  initial begin
    int ph;
    ph = 0;
    ce = 1'b1;
    forever begin
      @(negedge clk);
      if (ce_slow) begin
        ce = (ph == 0);
        ph = (ph == 2) ? 0 : ph + 1;
      end else begin
        ce = 1'b1;
        ph = 0;
      end
    end
  end

  // SPI model: answers each byte start with byte index n of the transfer
  initial begin
    logic wp, rp;
    int   n;
    ispi_dsr = 1'b0; ispi_data = 8'h00; wp = 1'b0; rp = 1'b1; n = 0;
    forever begin
      @(negedge clk);
      if (rp && !ready) n = 0;
      rp = ready;
      if (ospi_wr && !wp) begin
        repeat (3) @(negedge clk);
        ispi_data = 8'(n);
        ispi_dsr  = 1'b1;
        repeat (dsr_hold) @(negedge clk);
        ispi_dsr = 1'b0;
        n++;
      end
      wp = ospi_wr;
    end
  end

  // Monitor: checks every RAM write and every SPI byte start against the model
  initial begin
    logic              wr_p, wren_p, done_p, rdy_p;
    logic [ADDR_W-1:0] a;
    logic [7:0]        exp;
    wr_cnt = 0; wren_cnt = 0; done_cnt = 0; mon_err = 0;
    mon_base = '0; mon_dir = 1'b0;
    wr_p = 1'b0; wren_p = 1'b0; done_p = 1'b0; rdy_p = 1'b1;
    forever begin
      @(negedge clk);
      if (rdy_p && !ready) begin
        wr_cnt = 0; wren_cnt = 0; mon_base = iaddr; mon_dir = dir;
      end
      if (ospi_wr && !wr_p) begin
        a   = mon_base + ADDR_W'(wr_cnt);
        exp = mon_dir ? mem[a] : 8'hFF;
        if (ospi_data !== exp) mon_err++;
        wr_cnt++;
      end
      if (owren && !wren_p) begin
        a = mon_base + ADDR_W'(wren_cnt);
        if (oaddr !== a || odata !== 8'(wren_cnt) || mon_dir !== 1'b0) mon_err++;
        wren_cnt++;
      end
      if (done && !done_p) done_cnt++;
      wr_p = ospi_wr; wren_p = owren; done_p = done; rdy_p = ready;
    end
  end

  task automatic start_xfer(input logic d, input logic [NBLK_W-1:0] nb, input logic [ADDR_W-1:0] a);
    @(negedge clk);
    dir = d; nblocks = nb; iaddr = a; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    int t;
    t = 0;
    while (done_cnt <= d0 && t < LIMIT) begin
      @(negedge clk); #1;
      t++;
    end
    ok = (done_cnt > d0);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else n_pass++;
    n_checks++;
    if ({done, aborted, owren, ospi_wr, oaddr, odata, ospi_data, state_o} !== '0)
      $display("FAIL reset_outputs: got %h want 0", {done, aborted, owren, ospi_wr, oaddr, odata, ospi_data, state_o});
    else n_pass++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_block;
    int e0, d0, w;
    bit ok;
    e0 = mon_err; d0 = done_cnt;
    start_xfer(1'b0, 3'd1, 16'h8000);
    wait_done(d0, ok);
    w = 0;
    while (done && w < 10) begin w++; @(negedge clk); #1; end
    n_checks++; if (!ok) $display("FAIL read_finish: got no done want done"); else n_pass++;
    n_checks++; if (w !== 1) $display("FAIL read_done_width: got %0d want 1", w); else n_pass++;
    repeat (10) @(negedge clk);
    n_checks++; if (wren_cnt !== 512) $display("FAIL read_owren_count: got %0d want 512", wren_cnt); else n_pass++;
    n_checks++; if (wr_cnt !== 512) $display("FAIL read_spi_count: got %0d want 512", wr_cnt); else n_pass++;
    n_checks++; if (mon_err !== e0) $display("FAIL read_data: got %0d errors want 0", mon_err - e0); else n_pass++;
    n_checks++; if (done_cnt !== d0 + 1) $display("FAIL read_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
    n_checks++; if ({ready, aborted} !== 2'b10) $display("FAIL read_status: got %b want 10", {ready, aborted}); else n_pass++;
    n_checks++; if (oaddr !== 16'h8200) $display("FAIL read_end_addr: got %h want 8200", oaddr); else n_pass++;
  endtask

  task automatic test_write_two_blocks;
    int e0, d0;
    bit ok;
    e0 = mon_err; d0 = done_cnt;
    start_xfer(1'b1, 3'd2, 16'h1000);
    wait_done(d0, ok);
    repeat (10) @(negedge clk);
    n_checks++; if (!ok) $display("FAIL write_finish: got no done want done"); else n_pass++;
    n_checks++; if (wr_cnt !== 1024) $display("FAIL write_spi_count: got %0d want 1024", wr_cnt); else n_pass++;
    n_checks++; if (wren_cnt !== 0) $display("FAIL write_owren_count: got %0d want 0", wren_cnt); else n_pass++;
    n_checks++; if (mon_err !== e0) $display("FAIL write_data: got %0d errors want 0", mon_err - e0); else n_pass++;
    n_checks++; if (oaddr !== 16'h1400) $display("FAIL write_end_addr: got %h want 1400", oaddr); else n_pass++;
  endtask

  task automatic test_abort;
    int d0, t, cyc;
    d0 = done_cnt;
    start_xfer(1'b0, 3'd1, 16'h2000);
    t = 0;
    while (wr_cnt < 101 && t < LIMIT) begin @(negedge clk); #1; t++; end
    abort = 1'b1;
    cyc = 0;
    while (!done && cyc < 10) begin @(negedge clk); #1; cyc++; end
    abort = 1'b0;
    n_checks++; if (cyc > 2 || !done) $display("FAIL abort_done_latency: got %0d want <=2", cyc); else n_pass++;
    repeat (30) @(negedge clk);
    n_checks++; if (wr_cnt !== 101) $display("FAIL abort_spi_count: got %0d want 101", wr_cnt); else n_pass++;
    n_checks++; if (wren_cnt !== 100) $display("FAIL abort_owren_count: got %0d want 100", wren_cnt); else n_pass++;
    n_checks++; if (aborted !== 1'b1) $display("FAIL abort_flag: got %b want 1", aborted); else n_pass++;
    n_checks++; if (ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", ready); else n_pass++;
    n_checks++; if (done_cnt !== d0 + 1) $display("FAIL abort_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
    n_checks++; if (state_o !== 3'd0) $display("FAIL abort_state: got %0d want 0", state_o); else n_pass++;
  endtask

  task automatic test_async_reset;
    int d0, t;
    d0 = done_cnt;
    start_xfer(1'b0, 3'd1, 16'h4000);
    t = 0;
    while (wren_cnt < 50 && t < LIMIT) begin @(negedge clk); #1; t++; end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (ready !== 1'b1) $display("FAIL arst_ready: got %b want 1", ready); else n_pass++;
    n_checks++; if ({done, aborted, owren, ospi_wr} !== 4'b0) $display("FAIL arst_flags: got %b want 0000", {done, aborted, owren, ospi_wr}); else n_pass++;
    n_checks++; if (oaddr !== 16'h0000) $display("FAIL arst_oaddr: got %h want 0000", oaddr); else n_pass++;
    n_checks++; if ({odata, ospi_data} !== 16'h0000) $display("FAIL arst_data: got %h want 0000", {odata, ospi_data}); else n_pass++;
    n_checks++; if (state_o !== 3'd0) $display("FAIL arst_state: got %0d want 0", state_o); else n_pass++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (done_cnt !== d0) $display("FAIL arst_no_done: got %0d pulses want 0", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_wrap;
    int e0, d0;
    bit ok;
    e0 = mon_err; d0 = done_cnt;
    start_xfer(1'b0, 3'd1, 16'hFF00);
    wait_done(d0, ok);
    repeat (10) @(negedge clk);
    n_checks++; if (wren_cnt !== 512) $display("FAIL wrap_owren_count: got %0d want 512", wren_cnt); else n_pass++;
    n_checks++; if (mon_err !== e0) $display("FAIL wrap_addr_data: got %0d errors want 0", mon_err - e0); else n_pass++;
    n_checks++; if (done_cnt !== d0 + 1 || !ok) $display("FAIL wrap_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
    n_checks++; if (oaddr !== 16'h0100) $display("FAIL wrap_end_addr: got %h want 0100", oaddr); else n_pass++;
  endtask

  task automatic test_idle_ignores;
    int d0, w0;
    d0 = done_cnt; w0 = wr_cnt;
    start_xfer(1'b0, 3'd0, 16'h1234);
    repeat (10) @(negedge clk);
    n_checks++; if (ready !== 1'b1) $display("FAIL zero_ready: got %b want 1", ready); else n_pass++;
    n_checks++; if (state_o !== 3'd0) $display("FAIL zero_state: got %0d want 0", state_o); else n_pass++;
    n_checks++; if (wr_cnt !== w0 || done_cnt !== d0) $display("FAIL zero_activity: got wr %0d done %0d want 0 0", wr_cnt - w0, done_cnt - d0); else n_pass++;
    abort = 1'b1;
    repeat (5) @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (aborted !== 1'b0) $display("FAIL idle_abort_flag: got %b want 0", aborted); else n_pass++;
    n_checks++; if (done_cnt !== d0) $display("FAIL idle_abort_done: got %0d want 0", done_cnt - d0); else n_pass++;
    n_checks++; if ({ready, state_o} !== 4'b1000) $display("FAIL idle_abort_state: got %b want 1000", {ready, state_o}); else n_pass++;
  endtask

  task automatic test_ce_throttle;
    int e0, d0, w, w0;
    bit ok;
    ce_slow = 1'b1; dsr_hold = 3;
    e0 = mon_err; d0 = done_cnt;
    start_xfer(1'b0, 3'd1, 16'h8000);
    wait_done(d0, ok);
    w = 0;
    while (done && w < 10) begin w++; @(negedge clk); #1; end
    repeat (10) @(negedge clk);
    n_checks++; if (!ok) $display("FAIL ce_finish: got no done want done"); else n_pass++;
    n_checks++; if (w !== 3) $display("FAIL ce_done_width: got %0d clocks want 3", w); else n_pass++;
    n_checks++; if (wren_cnt !== 512 || wr_cnt !== 512) $display("FAIL ce_counts: got %0d/%0d want 512/512", wren_cnt, wr_cnt); else n_pass++;
    n_checks++; if (mon_err !== e0) $display("FAIL ce_data: got %0d errors want 0", mon_err - e0); else n_pass++;
    n_checks++; if (done_cnt !== d0 + 1) $display("FAIL ce_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
    n_checks++; if (oaddr !== 16'h8200 || aborted !== 1'b0) $display("FAIL ce_end: got %h/%b want 8200/0", oaddr, aborted); else n_pass++;
    w0 = wr_cnt;
    start_xfer(1'b0, 3'd0, 16'h0000);
    repeat (12) @(negedge clk);
    n_checks++; if (ready !== 1'b1 || wr_cnt !== w0 || done_cnt !== d0 + 1) $display("FAIL ce_zero_blocks: got ready %b wr %0d want 1 0", ready, wr_cnt - w0); else n_pass++;
    ce_slow = 1'b0; dsr_hold = 1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'((i * 7) ^ (i >> 8) ^ 8'h5A);
    reset_n = 1'b0; start = 1'b0; dir = 1'b0; abort = 1'b0;
    nblocks = '0; iaddr = '0;
    test_reset();
    test_read_block();
    test_write_two_blocks();
    test_abort();
    test_async_reset();
    test_wrap();
    test_idle_ignores();
    test_ce_throttle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_dma_mb.md
SPI_DMA_MB -- requirements
Module: spi_dma_mb

Interface
REQ-001 Parameter ADDR_W, default 16, RAM address width.
REQ-002 Parameter BLK_LOG2, default 9, log2 of block size in bytes (512).
REQ-003 Parameter NBLK_W, default 3, width of block-count input.
REQ-004 Parameter FILL, default 8'hFF, byte sent to SPI in read direction.
REQ-005 clk  in  1  system clock; all state changes on rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 ce  in  1  clock enable; state advances only on edges with ce=1.
REQ-008 start  in  1  level-sampled request, honoured only in IDLE.
REQ-009 dir  in  1  0: SPI to RAM (read), 1: RAM to SPI (write).
REQ-010 nblocks  in  NBLK_W  number of blocks; 0 means no transfer.
REQ-011 iaddr  in  ADDR_W  buffer start address, latched on accepted start.
REQ-012 abort  in  1  terminate active transfer.
REQ-013 oaddr  out  ADDR_W  RAM address bus.
REQ-014 odata  out  8  RAM write data (registered SPI byte).
REQ-015 idata  in  8  RAM read data, valid the cycle after oaddr is presented.
REQ-016 owren  out  1  RAM write strobe, active high.
REQ-017 ready  out  1  1 = idle; 0 = block owns address/data busses.
REQ-018 done  out  1  one-ce-cycle pulse at end of transfer (normal or aborted).
REQ-019 aborted  out  1  1 if last transfer ended by abort; held until next accepted start.
REQ-020 ospi_data  out  8  byte presented to SPI controller.
REQ-021 ispi_data  in  8  byte received from SPI controller.
REQ-022 ospi_wr  out  1  SPI byte-start strobe, one ce cycle.
REQ-023 ispi_dsr  in  1  SPI byte complete, ispi_data valid.
REQ-024 state_o  out  3  current FSM state encoding, for debug.

Function
REQ-025 States SHALL be IDLE, LOAD, WAIT, STORE, FIN.
REQ-026 IDLE: ready=1; start=1 with nblocks!=0 SHALL latch dir, nblocks into blkctr, oaddr<=iaddr, bytectr<=0, aborted<=0, ready<=0, go LOAD.
REQ-027 IDLE: start=1 with nblocks==0 SHALL be ignored (no done pulse, ready stays 1).
REQ-028 LOAD: ospi_data<=(dir ? idata : FILL), ospi_wr<=1, go WAIT.
REQ-029 WAIT: ospi_wr<=0; on ispi_dsr=1 odata<=ispi_data, owren<=~dir, go STORE; else remain.
REQ-030 STORE: owren<=0, oaddr<=oaddr+1 modulo 2^ADDR_W, bytectr<=bytectr+1 (BLK_LOG2 bits).
REQ-031 STORE with bytectr==2^BLK_LOG2-1: if blkctr==1 go FIN, else blkctr<=blkctr-1, bytectr<=0, go LOAD.
REQ-032 STORE otherwise: go LOAD.
REQ-033 owren SHALL be high exactly during STORE in read mode, with oaddr equal to target address of that byte.
REQ-034 Per-byte cost excluding SPI time: 3 ce cycles (LOAD, WAIT min 1, STORE).
REQ-035 FIN: done<=1 for one ce cycle, ready<=1, go IDLE; start in FIN cycle ignored.
REQ-036 abort=1 in LOAD/WAIT/STORE SHALL take priority: ospi_wr<=0, owren<=0, aborted<=1, go FIN.
REQ-037 abort in IDLE or FIN SHALL have no effect.
REQ-038 ispi_dsr outside WAIT SHALL be ignored.
REQ-039 Inputs start, dir, nblocks, iaddr SHALL be ignored while ready=0.
REQ-040 Total bytes transferred SHALL equal nblocks*2^BLK_LOG2 unless aborted.

Reset
REQ-041 reset_n=0 SHALL immediately force IDLE, ready=1, done=0, aborted=0, owren=0, ospi_wr=0, oaddr=0, odata=0, ospi_data=0, blkctr=0, bytectr=0, independent of clk and ce.
REQ-042 Reset mid-transfer SHALL discard the transfer with no done pulse.

Verification
REQ-043 Read, nblocks=1, iaddr=16'h8000, SPI model returns byte n=n[7:0] -> 512 owren pulses at 8000..81FF, data 00..FF repeating, ospi_data=FF, one done, aborted=0.
REQ-044 Write, nblocks=2, iaddr=16'h1000, RAM pre-filled -> 1024 ospi_wr, ospi_data matches RAM 1000..13FF in order, owren never high.
REQ-045 Read, iaddr=16'hFF00, nblocks=1 -> addresses FF00..FFFF then 0000..00FF (wrap), done once.
REQ-046 Abort asserted during WAIT of byte 100 -> no further ospi_wr/owren, done pulse within 2 ce cycles, aborted=1, ready=1.
REQ-047 ce toggled 1-of-3 cycles, nblocks=1 -> identical outputs sequence to ce=1 run, stretched; start with nblocks=0 -> no activity.
REQ-048 reset_n low asynchronously mid-block -> all outputs at reset values before next clk edge; subsequent start works normally.
